// File: rtl/sync_control_multi.sv
`default_nettype none
// ============================================================================
// Module      : sync_control_multi
// Description : Step-barrier controller for N diffusion channels. Each round
//               pulses rdy to every enabled channel, collects the rising
//               edges of finished, and advances l_step once every enabled
//               channel has arrived. Adds a start/abort handshake, a per-step
//               watchdog and a pending-channel status vector.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_control_multi #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STEPS  = 7,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       finished,
    output logic [N_CH-1:0]       rdy,
    output logic [DATA_WIDTH-1:0] l_step,
    output logic [N_CH-1:0]       pending,
    output logic                  busy,
    output logic                  all_done,
    output logic                  timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam logic [1:0] c_st_err  = 2'd3;

    // Watchdog counter only needs to reach TIMEOUT; a disabled watchdog keeps
    // a one-bit counter that never moves.
    localparam int unsigned           c_wd_w      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                    c_wd_en     = (TIMEOUT != 0);
    localparam logic [c_wd_w-1:0]     c_timeout   = c_wd_w'(TIMEOUT);
    localparam logic [c_wd_w-1:0]     c_wd_one    = c_wd_w'(1);
    localparam logic [DATA_WIDTH-1:0] c_max_steps = DATA_WIDTH'(MAX_STEPS);
    localparam logic [DATA_WIDTH-1:0] c_step_one  = DATA_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [N_CH-1:0]       r_en_mask;
    logic [N_CH-1:0]       r_arrived;
    logic [N_CH-1:0]       r_fin_q;
    logic [c_wd_w-1:0]     r_wd;
    logic [N_CH-1:0]       r_rdy;
    logic [DATA_WIDTH-1:0] r_l_step;
    logic [N_CH-1:0]       r_pending;
    logic                  r_busy;
    logic                  r_all_done;
    logic                  r_timeout;

    // ------------------------------------------------------------------------
    // Combinational terms
    // ------------------------------------------------------------------------
    logic [1:0]            w_state_nx;
    logic [N_CH-1:0]       w_rise;
    logic [N_CH-1:0]       w_arrived_nx;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_step_inc;
    logic                  w_last_step;
    logic                  w_wd_expire;
    logic                  w_start_ok;

    logic [N_CH-1:0]       w_mask_d;
    logic [N_CH-1:0]       w_arrived_d;
    logic [c_wd_w-1:0]     w_wd_d;
    logic [DATA_WIDTH-1:0] w_step_d;
    logic [N_CH-1:0]       w_pending_d;
    logic [N_CH-1:0]       w_rdy_d;

    // Only a fresh 0->1 transition of an enabled channel counts as arrival;
    // a level still high when a step opens is ignored until it drops.
    assign w_rise       = finished & ~r_fin_q & r_en_mask;
    assign w_arrived_nx = r_arrived | w_rise;
    assign w_release    = (w_arrived_nx == r_en_mask);
    assign w_step_inc   = r_l_step + c_step_one;
    assign w_last_step  = (w_step_inc == c_max_steps);
    assign w_wd_expire  = c_wd_en && (r_wd == c_timeout);
    // A start with an empty mask would never release, so it is refused.
    assign w_start_ok   = start && (ch_en != '0);

    // State register: asynchronous reset to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic: abort dominates, release dominates watchdog expiry.
    always_comb begin
        w_state_nx = r_state;
        if (abort) begin
            w_state_nx = c_st_idle;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (w_release) begin
                        w_state_nx = w_last_step ? c_st_done : c_st_run;
                    end else if (w_wd_expire) begin
                        w_state_nx = c_st_err;
                    end
                end
                default: begin
                    if (w_start_ok) begin
                        w_state_nx = c_st_run;
                    end
                end
            endcase
        end
    end

    // Output/datapath next values: barrier bookkeeping, step count, rdy pulse.
    always_comb begin
        w_mask_d    = r_en_mask;
        w_arrived_d = r_arrived;
        w_wd_d      = r_wd;
        w_step_d    = r_l_step;
        w_pending_d = r_pending;
        w_rdy_d     = '0;
        if (abort) begin
            w_arrived_d = '0;
            w_wd_d      = '0;
            w_pending_d = '0;
        end else if (r_state == c_st_run) begin
            if (w_release) begin
                w_step_d    = w_step_inc;
                w_arrived_d = '0;
                w_wd_d      = '0;
                if (w_last_step) begin
                    w_pending_d = '0;
                end else begin
                    w_rdy_d     = r_en_mask;
                    w_pending_d = r_en_mask;
                end
            end else if (!w_wd_expire) begin
                w_arrived_d = w_arrived_nx;
                w_wd_d      = c_wd_en ? (r_wd + c_wd_one) : r_wd;
                w_pending_d = r_en_mask & ~w_arrived_nx;
            end
            // On expiry pending is left frozen at its last RUN value.
        end else if (w_start_ok) begin
            w_mask_d    = ch_en;
            w_arrived_d = '0;
            w_wd_d      = '0;
            w_step_d    = '0;
            w_pending_d = ch_en;
            w_rdy_d     = ch_en;
        end
    end

    // Datapath and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_mask  <= '0;
            r_arrived  <= '0;
            r_fin_q    <= '0;
            r_wd       <= '0;
            r_rdy      <= '0;
            r_l_step   <= '0;
            r_pending  <= '0;
            r_busy     <= 1'b0;
            r_all_done <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_fin_q    <= finished;
            r_en_mask  <= w_mask_d;
            r_arrived  <= w_arrived_d;
            r_wd       <= w_wd_d;
            r_rdy      <= w_rdy_d;
            r_l_step   <= w_step_d;
            r_pending  <= w_pending_d;
            r_busy     <= (w_state_nx == c_st_run);
            r_all_done <= (w_state_nx == c_st_done);
            r_timeout  <= (w_state_nx == c_st_err);
        end
    end

    assign rdy      = r_rdy;
    assign l_step   = r_l_step;
    assign pending  = r_pending;
    assign busy     = r_busy;
    assign all_done = r_all_done;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: doc/sync_control_multi.md
# sync_control_multi

Step-barrier controller for N diffusion channels; the parametrised successor of the dual-channel lap controller. Each round it issues a one-cycle `rdy` pulse to every enabled channel, collects their `finished` rising edges, and advances `l_step` only when all enabled channels have arrived. It terminates after `MAX_STEPS` rounds. Beyond the dual version it adds a per-channel enable mask, an explicit start/abort handshake, a per-step watchdog timeout, and a pending-channel status vector for the PS.

## Interface
- `N_CH`, 4: number of channels; valid range 1..32.
- `DATA_WIDTH`, 32: width of `l_step`.
- `MAX_STEPS`, 7: rounds per run; valid range 1 to 2^DATA_WIDTH-1.
- `TIMEOUT`, 1024: maximum cycles per step; 0 disables the watchdog.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle run request from PS.
- `abort` in 1: single-cycle cancel request from PS.
- `ch_en` in N_CH: channel enable mask, sampled only when a start is accepted.
- `finished` in N_CH: per-channel completion level; only a rising edge counts.
- `rdy` out N_CH: one-cycle go pulse per enabled channel.
- `l_step` out DATA_WIDTH: number of completed rounds.
- `pending` out N_CH: enabled channels that have not yet arrived in the current step.
- `busy` out 1: high while in RUN.
- `all_done` out 1: high while in DONE.
- `timeout` out 1: high while in ERR.

## Operation
- States: IDLE, RUN, DONE, ERR.
- Reset values: state IDLE; all outputs 0; internal mask, arrived, finished_q and watchdog counter 0.
- Edge detect: `finished_q` registers `finished` every cycle. `rise = finished & ~finished_q & en_mask`.
- Channels must drop `finished` after `rdy`. A level still high at a step start is not counted.
- Start acceptance: `start` is accepted in IDLE, DONE or ERR when `ch_en != 0`.
  - A start with `ch_en == 0` is ignored and the state is unchanged.
  - On acceptance: latch `en_mask = ch_en`, set `l_step = 0`, clear arrived and the watchdog counter, pulse `rdy = ch_en`, go to RUN.
- `start` is ignored while in RUN.
- RUN:
  - `arrived_nx = arrived | rise`.
  - When `arrived_nx == en_mask` (release), `l_step` increments and arrived is cleared.
  - If the new `l_step == MAX_STEPS`: go to DONE with no `rdy`.
  - Otherwise pulse `rdy = en_mask` and restart the watchdog.
- `pending = en_mask & ~arrived` while in RUN. It is frozen at its last RUN value in ERR, and is 0 in IDLE and DONE.
- Watchdog: the counter increments every RUN cycle without a release.
  - When `TIMEOUT != 0` and the counter reaches `TIMEOUT` with no release that cycle: go to ERR.
  - `l_step` holds its value in ERR.
- `abort` in any state returns to IDLE and zeroes all outputs except `l_step`, which holds.
- Simultaneous events:
  - `abort` together with `start`: abort wins.
  - Release in the same cycle the watchdog expires: release wins.
- A repeat rise from a channel that has already arrived in the same step is ignored.
- `l_step` arithmetic is unsigned. It never exceeds `MAX_STEPS` and never wraps.
- Asserting `rst_n` low at any time, including mid-step, forces the reset values immediately. No partial state survives.

## Timing
- `start` sampled at edge t: `rdy` is high during cycle t+1 to t+2, `busy` is high from t+1.
- Final rising edge of `finished` sampled at edge t:
  - `l_step` updates at edge t.
  - The next `rdy` pulse is high for exactly one cycle after edge t.
- Barrier latency from the last finished edge to `rdy` is therefore 1 cycle.
- `all_done` is asserted in the cycle after the final release. It holds until the next accepted start, an abort, or reset.
- `timeout` is asserted the cycle after the counter reaches `TIMEOUT`.
- Every output is registered; none depends combinationally on an input.

## Test plan
- **Basic run.** N_CH=4, MAX_STEPS=3, ch_en=4'b1111. Each step, channels raise `finished` at staggered cycles 2/4/6/8 after `rdy`, then drop it.
  - Expect exactly 3 `rdy` pulses of 4'b1111 (the start pulse plus after releases 1 and 2), then `l_step` = 1, 2, 3.
  - After the third release: `all_done`=1 and no further `rdy`.
- **Masked channels.** ch_en=4'b0101 while channels 1 and 3 toggle `finished` freely.
  - Releases depend only on channels 0 and 2.
  - `rdy` pulses equal 4'b0101 and `pending` never shows bits 1 or 3.
- **Watchdog.** TIMEOUT=16; channel 2 never finishes in step 1.
  - `timeout`=1 exactly 17 cycles after the step-1 `rdy`.
  - `pending`=4'b0100 and `l_step`=1 hold.
  - A following start with ch_en=4'b1111 restarts from `l_step`=0.
- **Held level and repeat edges.** A channel holds `finished` high across `rdy` and is not counted until it falls and rises again. A double rise within one step releases only once.
- **Abort, reset and ignored start.**
  - `abort` and `start` in the same cycle mid-run: go to IDLE, `l_step` holds.
  - `rst_n` low mid-step: all outputs 0 immediately.
  - A start with ch_en=0 leaves the block in IDLE.
